// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, register
// address width and the bundle of pipeline-register control strobes.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic pcwrite;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic exmem_bubble;
    logic memwb_bubble;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_FLOW = '{
    pcwrite: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_write: 1'b1,
    idex_flush: 1'b0, exmem_write: 1'b1, exmem_bubble: 1'b0, memwb_bubble: 1'b0
  };

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX (x0 never creates a hazard).
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_memread_i,
  output logic                  stall_o
);

  always_comb begin
    stall_o = ex_memread_i && (ex_rd_i != '0) &&
              ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
               (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Prioritised stall/flush sequencer for the 5-stage pipeline.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned PERF_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mdu,
  input  logic                  mdu_done,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pcwrite,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_write,
  output logic                  idex_flush,
  output logic                  exmem_write,
  output logic                  exmem_bubble,
  output logic                  memwb_bubble,
  output logic [1:0]            ctrl_state,
  output logic                  mem_timeout,
  output logic [PERF_W-1:0]     perf_stall_cnt,
  output logic [PERF_W-1:0]     perf_flush_cnt
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             lu_stall, mem_stall, mdu_stall, mem_frozen;
  ctrl_out_t        ctrl;

  load_use_detect u_load_use (
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .ex_rd_i       (ex_rd),
    .ex_memread_i  (ex_memread),
    .stall_o       (lu_stall)
  );

  // Wait states only reshape the stall conditions; the priority chain is shared.
  always_comb begin
    mem_stall = dmem_req && !dmem_ready;
    mdu_stall = ex_mdu && !mdu_done;
    case (state_q)
      MEM_WAIT: mem_stall = !dmem_ready;
      MDU_WAIT: mdu_stall = !mdu_done;
      default:  ;
    endcase
  end

  always_comb begin
    ctrl    = CTRL_FLOW;
    state_d = RUN;
    if (mem_stall) begin
      ctrl              = '0;
      ctrl.memwb_bubble = 1'b1;
      state_d           = MEM_WAIT;
    end else if (mdu_stall) begin
      ctrl.pcwrite      = 1'b0;
      ctrl.ifid_write   = 1'b0;
      ctrl.idex_write   = 1'b0;
      ctrl.exmem_bubble = 1'b1;
      state_d           = MDU_WAIT;
    end else if (ex_branch_taken) begin
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
    end else if (lu_stall) begin
      ctrl.pcwrite    = 1'b0;
      ctrl.ifid_write = 1'b0;
      ctrl.idex_flush = 1'b1;
    end
    if (rst) begin
      ctrl = '0;
    end
  end

  always_comb begin
    mem_frozen = (state_q == MEM_WAIT) && !dmem_ready;
    cnt_d      = '0;
    if (mem_frozen) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end
    timeout_d = timeout_q || (mem_frozen && (cnt_d >= TIMEOUT_CNT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign pcwrite      = ctrl.pcwrite;
  assign ifid_write   = ctrl.ifid_write;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_write   = ctrl.idex_write;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_write  = ctrl.exmem_write;
  assign exmem_bubble = ctrl.exmem_bubble;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign ctrl_state   = state_q;
  assign mem_timeout  = timeout_q;

`ifdef PIPE_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!ctrl.pcwrite) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (ctrl.ifid_flush) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push hand-computed
// expectations; a monitor pops and compares once per cycle or on async reset.
module tb_pipeline_ctrl;

  // {pcwrite, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, exmem_bubble, memwb_bubble}
  localparam logic [7:0] DEF  = 8'b1101_0100;
  localparam logic [7:0] FRZ  = 8'b0000_0001;
  localparam logic [7:0] MDU  = 8'b0000_0110;
  localparam logic [7:0] BR   = 8'b1111_1100;
  localparam logic [7:0] LU   = 8'b0001_1100;
  localparam logic [7:0] ZERO = 8'b0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken;
  logic        ex_mdu, mdu_done, dmem_req, dmem_ready;
  logic        pcwrite, ifid_write, ifid_flush, idex_write, idex_flush;
  logic        exmem_write, exmem_bubble, memwb_bubble, mem_timeout;
  logic [1:0]  ctrl_state;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  typedef struct {
    string      nm;
    logic [7:0] outs;
    logic [1:0] st;
    logic       to;
    bit         chk_perf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8), .PERF_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .ex_mdu(ex_mdu), .mdu_done(mdu_done), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pcwrite(pcwrite), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
    .exmem_bubble(exmem_bubble), .memwb_bubble(memwb_bubble), .ctrl_state(ctrl_state),
    .mem_timeout(mem_timeout), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  task automatic push(input string nm, input logic [7:0] eo, input logic [1:0] es,
                      input logic et, input bit pf);
    exp_t e;
    e.nm = nm; e.outs = eo; e.st = es; e.to = et; e.chk_perf = pf;
    sb.push_back(e);
  endtask

  // Inputs are already applied; record the expectation and advance one cycle.
  task automatic cyc(input string nm, input logic [7:0] eo, input logic [1:0] es,
                     input logic et);
    push(nm, eo, es, et, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_memread = 0; ex_branch_taken = 0;
    ex_mdu = 0; mdu_done = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [7:0] act;
    bit         bad;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      if (sb.size() != 0) begin
        e   = sb.pop_front();
        act = {pcwrite, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_write, exmem_bubble, memwb_bubble};
        bad = (act !== e.outs) || (ctrl_state !== e.st) || (mem_timeout !== e.to);
        if (e.chk_perf && ((perf_stall_cnt !== '0) || (perf_flush_cnt !== '0))) bad = 1'b1;
        n_vec++;
        if (bad) begin
          n_err++;
          $display("FAIL %s: got outs=%b state=%0d timeout=%b perf=%0d/%0d, expected outs=%b state=%0d timeout=%b%s",
                   e.nm, act, ctrl_state, mem_timeout, perf_stall_cnt, perf_flush_cnt,
                   e.outs, e.st, e.to, e.chk_perf ? " perf=0/0" : "");
        end
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    push("reset_state", ZERO, 2'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("idle", DEF, 2'd0, 1'b0);

    // Load-use hazards
    ex_memread = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1;
    cyc("lu_rs1_hit", LU, 2'd0, 1'b0);
    idle();
    cyc("lu_release", DEF, 2'd0, 1'b0);
    ex_memread = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1;
    cyc("lu_x0", DEF, 2'd0, 1'b0);
    ex_memread = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1;
    cyc("lu_rs2_hit", LU, 2'd0, 1'b0);
    idle();
    ex_memread = 1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 0;
    cyc("lu_unused", DEF, 2'd0, 1'b0);
    ex_memread = 0; id_uses_rs1 = 1;
    cyc("lu_noload", DEF, 2'd0, 1'b0);

    // Branch wins over load-use
    ex_memread = 1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1; ex_branch_taken = 1;
    cyc("br_over_lu", BR, 2'd0, 1'b0);
    idle();

    // Three-cycle memory stall
    dmem_req = 1; dmem_ready = 0;
    cyc("mem_c1", FRZ, 2'd0, 1'b0);
    cyc("mem_c2", FRZ, 2'd1, 1'b0);
    cyc("mem_c3", FRZ, 2'd1, 1'b0);
    dmem_ready = 1;
    cyc("mem_rel", DEF, 2'd1, 1'b0);
    idle();
    cyc("mem_after", DEF, 2'd0, 1'b0);

    // Branch held during freeze is applied on release
    dmem_req = 1; ex_branch_taken = 1;
    cyc("brfrz_c1", FRZ, 2'd0, 1'b0);
    dmem_ready = 1;
    cyc("brfrz_rel", BR, 2'd1, 1'b0);
    idle();
    cyc("brfrz_after", DEF, 2'd0, 1'b0);

    // Timeout after four MEM_WAIT cycles, sticky afterwards
    dmem_req = 1;
    cyc("to_c1", FRZ, 2'd0, 1'b0);
    cyc("to_c2", FRZ, 2'd1, 1'b0);
    cyc("to_c3", FRZ, 2'd1, 1'b0);
    cyc("to_c4", FRZ, 2'd1, 1'b0);
    cyc("to_c5", FRZ, 2'd1, 1'b0);
    cyc("to_c6", FRZ, 2'd1, 1'b1);
    cyc("to_c7", FRZ, 2'd1, 1'b1);
    cyc("to_c8", FRZ, 2'd1, 1'b1);
    dmem_ready = 1;
    cyc("to_rel", DEF, 2'd1, 1'b1);
    idle();
    cyc("to_sticky", DEF, 2'd0, 1'b1);

    // MDU occupancy interrupted by a memory stall
    ex_mdu = 1;
    cyc("mdu_c1", MDU, 2'd0, 1'b1);
    dmem_req = 1; dmem_ready = 0;
    cyc("mdu_c2", FRZ, 2'd2, 1'b1);
    cyc("mdu_c3", FRZ, 2'd1, 1'b1);
    dmem_ready = 1;
    cyc("mdu_c4", MDU, 2'd1, 1'b1);
    dmem_req = 0; dmem_ready = 0;
    cyc("mdu_c5", MDU, 2'd2, 1'b1);
    mdu_done = 1;
    cyc("mdu_done", DEF, 2'd2, 1'b1);
    idle();
    cyc("mdu_after", DEF, 2'd0, 1'b1);

    // Asynchronous reset in the middle of MEM_WAIT
    dmem_req = 1;
    cyc("ar_c1", FRZ, 2'd0, 1'b1);
    cyc("ar_c2", FRZ, 2'd1, 1'b1);
    #2;
    push("async_rst", ZERO, 2'd0, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    cyc("rst_hold", ZERO, 2'd0, 1'b0);
    rst = 1'b0;
    idle();
    cyc("post_rst", DEF, 2'd0, 1'b0);

    repeat (3) @(negedge clk);
    #3;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
